calc_drv: RTL and testbench

CALC_DRV -- requirements
Module: calc_drv

---
 rtl/calc_drv.sv | 126 ++++++++++++
 tb/tb_calc_drv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_drv.sv
// calc_drv: drives operand triples into a three-lane calculator and collects
// its results into a first-word-fall-through FIFO.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   in_valid/in_ready     upstream operand triple handshake
//   in_A, in_B, in_C      upstream operands
//   A, B, C               operands to calculator (held while any lane pending)
//   pushA/B/C, stopA/B/C  per-lane push / stop handshake with calculator
//   Z, pushZ              result from calculator (no backpressure)
//   out_valid/out_data/out_ready  downstream result stream
//   err                   sticky protocol error (unexpected or unstorable Z)
module calc_drv #(
  parameter int unsigned RDEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  input  logic [31:0] in_C,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] C,
  output logic        pushA,
  output logic        pushB,
  output logic        pushC,
  input  logic        stopA,
  input  logic        stopB,
  input  logic        stopC,
  input  logic [31:0] Z,
  input  logic        pushZ,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(RDEPTH);
  localparam logic [AW:0]   ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_C = RDEPTH[AW:0];
  localparam logic [AW+1:0] DEPTH_W = RDEPTH[AW+1:0];

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic        pend_a, pend_b, pend_c;
  logic [AW:0] inflight;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [RDEPTH];

  logic [AW+1:0] credit_used;
  logic accept, launch, pop, z_ok;

  // Every accepted triple reserves one FIFO slot until its result is popped,
  // so a returning Z can always be stored.
  assign credit_used = {1'b0, inflight} + {1'b0, count};
  assign in_ready    = rst && (state == IDLE) && (credit_used < DEPTH_W);
  assign accept      = in_valid && in_ready;

  // Last pending lane(s) transfer this cycle: no lane is still pending and stopped.
  assign launch = (state == SEND) &&
                  !((pend_a && stopA) || (pend_b && stopB) || (pend_c && stopC));

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign z_ok      = pushZ && (inflight != '0) && ((count != DEPTH_C) || pop);

  assign pushA = pend_a;
  assign pushB = pend_b;
  assign pushC = pend_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      pend_c   <= 1'b0;
      A        <= '0;
      B        <= '0;
      C        <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        A      <= in_A;
        B      <= in_B;
        C      <= in_C;
        pend_a <= 1'b1;
        pend_b <= 1'b1;
        pend_c <= 1'b1;
        state  <= SEND;
      end else if (state == SEND) begin
        if (pend_a && !stopA) pend_a <= 1'b0;
        if (pend_b && !stopB) pend_b <= 1'b0;
        if (pend_c && !stopC) pend_c <= 1'b0;
        if (launch) state <= IDLE;
      end

      if (pushZ && !z_ok) err <= 1'b1;

      if (launch && !z_ok)      inflight <= inflight + ONE;
      else if (!launch && z_ok) inflight <= inflight - ONE;

      if (z_ok) wr_ptr <= wr_ptr + ONE[AW-1:0];
      if (pop)  rd_ptr <= rd_ptr + ONE[AW-1:0];

      if (z_ok && !pop)      count <= count + ONE;
      else if (!z_ok && pop) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && z_ok) mem[wr_ptr] <= Z;
  end

endmodule

// File: tb/tb_calc_drv.sv
module tb_calc_drv;
  localparam int RDEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_A = '0, in_B = '0, in_C = '0;
  logic [31:0] A, B, C;
  logic        pushA, pushB, pushC;
  logic        stopA = 1'b0, stopB = 1'b0, stopC = 1'b0;
  logic [31:0] Z = '0;
  logic        pushZ = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  calc_drv #(.RDEPTH(RDEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_C(in_C),
    .A(A), .B(B), .C(C),
    .pushA(pushA), .pushB(pushB), .pushC(pushC),
    .stopA(stopA), .stopB(stopB), .stopC(stopC),
    .Z(Z), .pushZ(pushZ),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Reference model: a triple in flight, which lanes still owe a transfer,
  // outstanding result count and the expected result queue.
  bit          m_busy = 0;
  bit [2:0]    m_left = '0;
  logic [31:0] m_ops [3] = '{32'd0, 32'd0, 32'd0};
  int          m_inflight = 0;
  logic [31:0] m_q [$];
  bit          m_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input bit sa, input bit sb, input bit sc,
                       input bit pz, input logic [31:0] z, input bit ordy);
    in_valid = v; in_A = a; in_B = b; in_C = c;
    stopA = sa; stopB = sb; stopC = sc;
    pushZ = pz; Z = z; out_ready = ordy;
  endtask

  function automatic bit exp_ready();
    return (rst === 1'b1) && !m_busy && (m_inflight + m_q.size() < RDEPTH);
  endfunction

  // Compare outputs against the model, advance the model with the current
  // inputs, then move to the next falling edge.
  task automatic step();
    bit acc, pop, zok, done;
    bit [2:0] stops;
    #1;
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(exp_ready()));
      check("pushA", 32'(pushA), 32'(m_left[0]));
      check("pushB", 32'(pushB), 32'(m_left[1]));
      check("pushC", 32'(pushC), 32'(m_left[2]));
      check("A", A, m_ops[0]);
      check("B", B, m_ops[1]);
      check("C", C, m_ops[2]);
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
      check("err", 32'(err), 32'(m_err));
      check("inflight", 32'(dut.inflight), 32'(m_inflight));
      check("fifo_count", 32'(dut.count), 32'(m_q.size()));
    end
    if (rst !== 1'b1) begin
      m_busy = 0; m_left = '0; m_ops = '{32'd0, 32'd0, 32'd0};
      m_inflight = 0; m_q.delete(); m_err = 0;
    end else begin
      acc   = in_valid && exp_ready();
      pop   = (m_q.size() > 0) && out_ready;
      stops = {stopC, stopB, stopA};
      done  = 0;
      if (m_busy) begin
        m_left = m_left & stops;
        if (m_left == '0) begin m_busy = 0; done = 1; end
      end
      zok = pushZ && (m_inflight > 0) && ((m_q.size() < RDEPTH) || pop);
      if (pushZ && !zok) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (zok) m_q.push_back(Z);
      m_inflight = m_inflight + int'(done) - int'(zok);
      if (acc) begin
        m_busy = 1; m_left = 3'b111;
        m_ops = '{in_A, in_B, in_C};
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
  endtask

  task automatic idle(input int n, input bit ordy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2, 0);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(1, 0);

    // Single triple, then its result.
    drive(1, 2, 3, 4, 0, 0, 0, 0, 0, 0); step();
    idle(2, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 173, 0); step();
    idle(1, 0);
    check("single_out_data", out_data, 32'd173);
    idle(2, 1);

    // Staggered stop on lane B.
    drive(1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); step();
    end
    idle(2, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF, 1); step();
    idle(2, 1);

    // Credit limit: fill with the sink stalled, then one pop frees a credit.
    for (int i = 0; i < RDEPTH; i++) begin
      drive(1, i, i + 1, i + 2, 0, 0, 0, 0, 0, 0); step();
      idle(1, 0);
    end
    for (int i = 0; i < RDEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h100 + i, 0); step();
    end
    idle(1, 0);
    check("credit_full_ready", 32'(in_ready), 32'd0);
    idle(1, 1);
    idle(1, 0);
    check("credit_freed_ready", 32'(in_ready), 32'd1);
    idle(RDEPTH + 1, 1);

    // Launch completion and pushZ on the same edge with three in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 8, 9, 0, 0, 0, 0, 0, 1); step();
      idle(1, 1);
    end
    drive(1, 5, 6, 7, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A, 1); step();
    check("net_zero_inflight", 32'(dut.inflight), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h600 + i, 1); step();
    end
    idle(4, 1);

    // Unexpected result: sticky error, nothing stored, cleared by reset.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'd55, 1); step();
    idle(3, 1);
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    idle(1, 1);

    // Reset while lane B is still pending.
    drive(1, 1, 2, 3, 0, 1, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); step();
    rst = 1'b0;
    step();
    check("rst_pushB", 32'(pushB), 32'd0);
    rst = 1'b1;
    idle(2, 1);

    // Randomized traffic, with periodic sink stalls to reach the credit limit.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            (m_inflight > 0) && ($urandom_range(0, 2) == 0), $urandom,
            ((i % 150) < 90) && ($urandom_range(0, 3) != 0));
      step();
    end
    idle(20, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1);
  end
endmodule
